// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word read at a time to instruction
// memory and buffers returned instructions with their PCs in a prefetch FIFO.
// A redirect flushes the FIFO and any in-flight read, then restarts fetch.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic [31:0] fetch_pc
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StReq, StWait, StDrop} fetchStateT;

   fetchStateT      stateQ, stateD;
   logic [31:0]     fetchPcQ, fetchPcD;
   logic [31:0]     reqPcQ;
   logic [31:0]     fifoInstr [FIFO_DEPTH];
   logic [31:0]     fifoPc    [FIFO_DEPTH];
   logic [PtrW-1:0] wrPtrQ, rdPtrQ;
   logic [CntW-1:0] countQ;
   logic            reqFire, push, pop, notFull;
   logic [31:0]     redirectTarget;

   // Word-align the redirect target; the low two bits are never used.
   assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;
   assign notFull        = countQ < DepthCnt;

   assign mem_req_addr = fetchPcQ;
   assign fetch_pc     = fetchPcQ;
   assign instr_valid  = (countQ != '0) && !reset;
   assign instr        = fifoInstr[rdPtrQ];
   assign instr_pc     = fifoPc[rdPtrQ];
   // A redirect flushes the FIFO, so it overrides a concurrent pop.
   assign pop          = instr_valid && instr_ready && !redirect_valid;

   // Next-state, request issue and push decision.
   always_comb begin
      stateD        = stateQ;
      fetchPcD      = fetchPcQ;
      mem_req_valid = 1'b0;
      reqFire       = 1'b0;
      push          = 1'b0;
      unique case (stateQ)
         StReq: begin
            mem_req_valid = notFull && !redirect_valid && !reset;
            reqFire       = mem_req_valid && mem_req_ready;
            if (reqFire) begin
               fetchPcD = fetchPcQ + 32'd4;
               stateD   = StWait;
            end
         end
         StWait: begin
            if (redirect_valid) begin
               // A response landing with the redirect is stale and discarded.
               stateD = mem_resp_valid ? StReq : StDrop;
            end else if (mem_resp_valid) begin
               push   = 1'b1;
               stateD = StReq;
            end
         end
         StDrop: begin
            if (mem_resp_valid) stateD = StReq;
         end
         default: stateD = StReq;
      endcase
      if (redirect_valid) fetchPcD = redirectTarget;
   end

   // FSM state, fetch PC and PC of the outstanding request.
   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ   <= StReq;
         fetchPcQ <= RESET_PC;
         reqPcQ   <= RESET_PC;
      end else begin
         stateQ   <= stateD;
         fetchPcQ <= fetchPcD;
         if (reqFire) reqPcQ <= fetchPcQ;
      end
   end

   // FIFO pointers and occupancy; reset and redirect both empty the FIFO.
   always_ff @(posedge clock) begin
      if (reset || redirect_valid) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         if (push) wrPtrQ <= wrPtrQ + 1'b1;
         if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
         case ({push, pop})
            2'b10:   countQ <= countQ + 1'b1;
            2'b01:   countQ <= countQ - 1'b1;
            default: countQ <= countQ;
         endcase
      end
   end

   // FIFO storage, written at the tail on every push.
   always_ff @(posedge clock) begin
      if (push) begin
         fifoInstr[wrPtrQ] <= mem_resp_data;
         fifoPc[wrPtrQ]    <= reqPcQ;
      end
   end

   // Requests are only issued with room left, so a push at full means a bug.
   pushAtFull: assert property (@(posedge clock) disable iff (reset)
      !(push && countQ == DepthCnt));

   // Memory must not answer when no request is outstanding.
   respInReq: assert property (@(posedge clock) disable iff (reset)
      !(stateQ == StReq && mem_resp_valid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory model with configurable latency, a
// scoreboard of expected FIFO contents, a per-cycle vector table and directed
// redirect/reset sequences.
module tb_instr_fetch_unit;

   localparam logic [31:0] ResetPc = 32'h0000_0000;
   localparam int          Depth   = 4;

   logic        clock;
   logic        reset;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic [31:0] fetch_pc;

   instr_fetch_unit #(
      .RESET_PC  (ResetPc),
      .FIFO_DEPTH(Depth)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready),
      .fetch_pc      (fetch_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Scoreboard: expected FIFO entries {pc, data}, oldest first.
   logic [63:0] sb[$];
   bit          outstanding = 0;
   bit          dropPending = 0;
   logic [31:0] pendAddr    = '0;
   int          pendDelay   = 0;
   logic [31:0] expPc       = ResetPc;
   int          memLat      = 1;
   bit          overrideOn  = 0;
   logic [31:0] overrideData = '0;

   typedef struct {
      bit          rdy;
      bit          expRv;
      logic [31:0] expAddr;
      bit          expIv;
      logic [31:0] expPcHead;
   } vecT;

   vecT vecs[14];

   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs just after posedge, check at negedge, update the
   // model for the coming posedge, then wait for it.
   task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc,
                       output bit sRv, output logic [31:0] sAddr, output bit sIv,
                       output logic [31:0] sPc, output logic [31:0] sInstr);
      bit          respNow;
      bit          expRv;
      bit          expIv;
      logic [31:0] respData;
      respNow  = 0;
      respData = '0;
      if (!r && outstanding) begin
         pendDelay--;
         if (pendDelay <= 0) begin
            respNow  = 1;
            respData = overrideOn ? overrideData : memData(pendAddr);
            overrideOn = 0;
         end
      end
      reset          = r;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      mem_req_ready  = 1'b1;
      mem_resp_valid = respNow;
      mem_resp_data  = respData;
      @(negedge clock);
      sRv    = mem_req_valid;
      sAddr  = mem_req_addr;
      sIv    = instr_valid;
      sPc    = instr_pc;
      sInstr = instr;
      expRv  = !r && !outstanding && (sb.size() < Depth) && !rv;
      expIv  = !r && (sb.size() != 0);
      chk("req_valid", {31'b0, mem_req_valid}, {31'b0, expRv});
      if (expRv) chk("req_addr", mem_req_addr, expPc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, expIv});
      if (expIv) begin
         chk("instr", instr, sb[0][31:0]);
         chk("instr_pc", instr_pc, sb[0][63:32]);
      end
      if (!r) chk("fetch_pc", fetch_pc, expPc);
      if (r) begin
         sb.delete();
         outstanding = 0;
         dropPending = 0;
         expPc       = ResetPc;
      end else if (rv) begin
         sb.delete();
         if (outstanding && !respNow) dropPending = 1;
         else begin
            outstanding = 0;
            dropPending = 0;
         end
         expPc = rpc & 32'hFFFF_FFFC;
      end else begin
         if (rdy && sb.size() != 0) void'(sb.pop_front());
         if (respNow) begin
            if (!dropPending) sb.push_back({pendAddr, respData});
            outstanding = 0;
            dropPending = 0;
         end
         if (expRv && mem_req_ready) begin
            outstanding = 1;
            pendAddr    = expPc;
            pendDelay   = memLat;
            expPc       = expPc + 32'd4;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      bit          a, c;
      logic [31:0] b, d, e;
      step(1, 0, 0, '0, a, b, c, d, e);
      step(1, 0, 0, '0, a, b, c, d, e);
   endtask

   initial begin
      bit          sRv, sIv;
      logic [31:0] sAddr, sPc, sInstr;
      bit          sawBad;

      reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;

      // Fill with no consumer, then one pop frees a slot for 0x10.
      vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
      vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4};
      vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4};

      // Reset state, first requests, fill to full and single pop.
      memLat = 1;
      doReset();
      for (int i = 0; i < 14; i++) begin
         step(0, vecs[i].rdy, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
         chk($sformatf("vec%0d_rv", i), {31'b0, sRv}, {31'b0, vecs[i].expRv});
         if (vecs[i].expRv) chk($sformatf("vec%0d_addr", i), sAddr, vecs[i].expAddr);
         chk($sformatf("vec%0d_iv", i), {31'b0, sIv}, {31'b0, vecs[i].expIv});
         if (vecs[i].expIv) chk($sformatf("vec%0d_pc", i), sPc, vecs[i].expPcHead);
      end

      // Redirect while waiting; the late response must be dropped.
      doReset();
      memLat       = 3;
      overrideOn   = 1;
      overrideData = 32'hDEAD_BEEF;
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 0, 1, 32'h0000_0043, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("redir_empty", {31'b0, sIv}, 32'd0);
      memLat = 1;
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("redir_req_valid", {31'b0, sRv}, 32'd1);
      chk("redir_req_addr", sAddr, 32'h0000_0040);
      sawBad = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
         if (i == 1) chk("redir_first_pc", sPc, 32'h0000_0040);
         if (sIv && sInstr == 32'hDEAD_BEEF) sawBad = 1;
      end
      chk("dropped_data_seen", {31'b0, sawBad}, 32'd0);

      // Redirect together with a response and a pop.
      doReset();
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 1, 1, 32'h0000_0200, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("combo_empty", {31'b0, sIv}, 32'd0);
      chk("combo_req_valid", {31'b0, sRv}, 32'd1);
      chk("combo_req_addr", sAddr, 32'h0000_0200);
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);

      // PC wrap at the top of the address space.
      doReset();
      step(0, 1, 1, 32'hFFFF_FFFC, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("wrap_addr_hi", sAddr, 32'hFFFF_FFFC);
      step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("wrap_addr_lo", sAddr, 32'h0000_0000);
      chk("wrap_pc_hi", sPc, 32'hFFFF_FFFC);
      step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("wrap_pc_lo", sPc, 32'h0000_0000);

      // Reset in the middle of a transaction with three queued entries.
      doReset();
      for (int i = 0; i < 7; i++) step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      step(1, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("rst_iv", {31'b0, sIv}, 32'd0);
      chk("rst_rv", {31'b0, sRv}, 32'd0);
      step(0, 0, 0, '0, sRv, sAddr, sIv, sPc, sInstr);
      chk("post_rst_rv", {31'b0, sRv}, 32'd1);
      chk("post_rst_addr", sAddr, ResetPc);
      chk("post_rst_iv", {31'b0, sIv}, 32'd0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, '0, sRv, sAddr, sIv, sPc, sInstr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
